unidade_de_busca: RTL
=====================

Name: unidade_de_busca

Overview:
Instruction fetch stage sitting directly upstream of the instruction memory. Holds the program counter, drives the memory read address, and captures the returned instruction into an IF/ID output register with a valid/ready handshake toward the decoder. Handles stalls, branch redirects with flush, and end-of-program detection. End of program is signalled by the memory's end flag or by an all-zero instruction word.

Parameters:
ENDERECO_INICIAL, 32'h0000_0000, PC value loaded at reset; must be word aligned.
PASSO, 4, PC increment per accepted fetch, in bytes.

Ports:
clock  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous, active-low reset
EnderecoDeLeitura  output  32  current PC, driven to the instruction memory; combinational from the PC register
Instrucao  input  32  instruction word returned by memory in the same cycle for EnderecoDeLeitura
arquivoFinalDele  input  1  memory end-of-program flag
DesvioTomado  input  1  redirect request from execute, one-cycle pulse
EnderecoDesvio  input  32  redirect target
Pronto  input  1  decoder ready to accept the IF/ID register
Valido  output  1  IF/ID register holds a valid instruction
InstrucaoSaida  output  32  captured instruction
PCSaida  output  32  address the captured instruction was fetched from
Fim  output  1  fetch halted on end of program
ErroAlinhamento  output  1  one-cycle pulse when a redirect target has a nonzero [1:0]
ContadorBuscas  output  32  number of instructions loaded into IF/ID since reset; wraps at 2^32

Behaviour:
- Reset (reset_n low, asynchronous; takes effect mid-operation too):
  - PC = ENDERECO_INICIAL.
  - Valido, InstrucaoSaida, PCSaida, Fim, ErroAlinhamento and ContadorBuscas = 0.
  - State = BUSCANDO.
- States: BUSCANDO (fetching), FIM (halted). All transitions occur on the clock edge.
- Definitions:
  - aceita = Pronto & Valido.
  - livre = ~Valido | Pronto.
  - fimDetectado = arquivoFinalDele | (Instrucao == 0).
- Priority per cycle: DesvioTomado > end detection > normal fetch > hold.
- DesvioTomado=1 (any state):
  - PC <= {EnderecoDesvio[31:2], 2'b00}; Valido <= 0 (flush, regardless of Pronto).
  - Fim <= 0; state <= BUSCANDO; ContadorBuscas unchanged.
  - If EnderecoDesvio[1:0] != 0, ErroAlinhamento = 1 for that one cycle.
- BUSCANDO, livre, fimDetectado=1:
  - No load. Valido <= 0; PC holds; Fim <= 1; state <= FIM.
- BUSCANDO, livre, fimDetectado=0:
  - InstrucaoSaida <= Instrucao; PCSaida <= PC; Valido <= 1.
  - PC <= PC + PASSO, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - ContadorBuscas += 1.
- BUSCANDO, ~livre (Valido=1, Pronto=0): stall. PC, InstrucaoSaida, PCSaida and Valido hold; memory is re-read at the same address next cycle.
- FIM:
  - PC frozen.
  - If aceita, Valido <= 0; otherwise outputs hold.
  - Leaves FIM only via DesvioTomado or reset.
- Latency: the instruction at address A is presented on InstrucaoSaida with Valido=1 one cycle after the cycle in which PC==A and livre=1. Throughput is one instruction per cycle while Pronto=1.
- Simultaneous DesvioTomado and aceita: the transfer to the decoder completes, then the flush applies. The decoder must treat the word presented in the redirect cycle as consumed.
- An X on Instrucao or arquivoFinalDele is not masked; the bench keeps these inputs defined after reset.

Test Plan:
- Reset with ENDERECO_INICIAL=0, memory holding 5 nonzero words then 0, Pronto=1 -> EnderecoDeLeitura steps 0,4,8,12,16,20. PCSaida 0..16 on consecutive cycles with Valido=1. Fim=1 the cycle after PC=20; ContadorBuscas=5.
- Pronto held 0 for 3 cycles after the first load -> Valido=1, InstrucaoSaida/PCSaida (0) and EnderecoDeLeitura (4) stable for 3 cycles. Resumes at 4 the cycle Pronto=1.
- DesvioTomado pulse with EnderecoDesvio=32'h40 while Valido=1 -> next cycle Valido=0 and EnderecoDeLeitura=32'h40. The following cycle PCSaida=32'h40.
- While in FIM, pulse DesvioTomado with EnderecoDesvio=32'h0000_0022 -> ErroAlinhamento=1 for one cycle, PC=32'h20, Fim=0, fetching resumes.
- Redirect to 32'hFFFF_FFFC with a nonzero word there -> PCSaida=32'hFFFF_FFFC, next EnderecoDeLeitura=0.
- Assert reset_n=0 mid-stall between clock edges -> all outputs 0 and PC=ENDERECO_INICIAL immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/unidade_de_busca.sv
// Instruction fetch stage: PC, memory address, IF/ID register.
// Handles decoder back-pressure, redirects with flush, and end of program.
module unidade_de_busca #(
  parameter logic [31:0] ENDERECO_INICIAL = 32'h0000_0000,
  parameter int          PASSO            = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] EnderecoDeLeitura,
  input  logic [31:0] Instrucao,
  input  logic        arquivoFinalDele,
  input  logic        DesvioTomado,
  input  logic [31:0] EnderecoDesvio,
  input  logic        Pronto,
  output logic        Valido,
  output logic [31:0] InstrucaoSaida,
  output logic [31:0] PCSaida,
  output logic        Fim,
  output logic        ErroAlinhamento,
  output logic [31:0] ContadorBuscas
);

  typedef enum logic {BUSCANDO, FIM} estado_t;

  estado_t     estado;
  estado_t     proxEstado;
  logic [31:0] pc;
  logic [31:0] proxPc;
  logic        proxValido;
  logic [31:0] proxInstrucao;
  logic [31:0] proxPcSaida;
  logic        proxFim;
  logic        proxErro;
  logic [31:0] proxContador;

  logic aceita;
  logic livre;
  logic fimDetectado;

  assign EnderecoDeLeitura = pc;
  assign aceita       = Pronto & Valido;
  assign livre        = ~Valido | Pronto;
  assign fimDetectado = arquivoFinalDele | (Instrucao == 32'h0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado          <= BUSCANDO;
      pc              <= ENDERECO_INICIAL;
      Valido          <= 1'b0;
      InstrucaoSaida  <= '0;
      PCSaida         <= '0;
      Fim             <= 1'b0;
      ErroAlinhamento <= 1'b0;
      ContadorBuscas  <= '0;
    end else begin
      estado          <= proxEstado;
      pc              <= proxPc;
      Valido          <= proxValido;
      InstrucaoSaida  <= proxInstrucao;
      PCSaida         <= proxPcSaida;
      Fim             <= proxFim;
      ErroAlinhamento <= proxErro;
      ContadorBuscas  <= proxContador;
    end
  end

  always_comb begin
    proxEstado    = estado;
    proxPc        = pc;
    proxValido    = Valido;
    proxInstrucao = InstrucaoSaida;
    proxPcSaida   = PCSaida;
    proxFim       = Fim;
    proxErro      = 1'b0;
    proxContador  = ContadorBuscas;
    if (DesvioTomado) begin
      // Flush wins over everything; a word accepted this cycle still counts as consumed.
      proxPc     = {EnderecoDesvio[31:2], 2'b00};
      proxValido = 1'b0;
      proxFim    = 1'b0;
      proxEstado = BUSCANDO;
      proxErro   = |EnderecoDesvio[1:0];
    end else if (estado == FIM) begin
      if (aceita) proxValido = 1'b0;
    end else if (livre && fimDetectado) begin
      proxValido = 1'b0;
      proxFim    = 1'b1;
      proxEstado = FIM;
    end else if (livre) begin
      proxInstrucao = Instrucao;
      proxPcSaida   = pc;
      proxValido    = 1'b1;
      proxPc        = pc + 32'(PASSO);
      proxContador  = ContadorBuscas + 32'd1;
    end
  end

endmodule
